// File: rtl/fifo_drain_skid.sv
// Drain stage for the circular-pointer FIFO: pops the FIFO and re-presents the
// words as a registered valid/ready stream through a 2-entry skid buffer.
module fifo_drain_skid #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_pop,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occ,
   output logic [CNTW-1:0]  xfer_cnt
);

   // Skid occupancy doubles as the FSM state; encoding 3 is never entered.
   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [CNTW-1:0]  cnt_q;
   logic             take, give;

   // Handshake: a word moves on a rising clk edge when out_valid & out_ready;
   // once out_valid is high, out_valid and out_data hold until that edge.
   // fifo_pop looks only at registered occupancy, so out_ready never reaches it.
   assign fifo_pop  = !rst && !flush && !fifo_empty && (state_q != S2);
   assign take      = fifo_pop;
   assign out_valid = (state_q != S0);
   assign give      = out_valid && out_ready;
   assign out_data  = head_q;
   assign occ       = state_q;
   assign xfer_cnt  = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S0;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         if (give) begin
            cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
         end
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         state_d = S0;
      end else begin
         case (state_q)
            S0: begin
               if (take) begin
                  state_d = S1;
                  head_d  = fifo_data;
               end
            end
            S1: begin
               if (take && !give) begin
                  state_d = S2;
                  tail_d  = fifo_data;
               end else if (take && give) begin
                  head_d = fifo_data;
               end else if (give) begin
                  state_d = S0;
               end
            end
            S2: begin
               // take is structurally 0 here, so only a give can move us
               if (give) begin
                  state_d = S1;
                  head_d  = tail_q;
               end
            end
            default: state_d = S0;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_drain_skid.sv
// Bench for fifo_drain_skid: a behavioural FIFO feeds the DUT, a vector table
// covers streaming and back-pressure, hand sequences cover flush/reset/wrap.
module tb_fifo_drain_skid;

   localparam int W = 8;
   localparam int C = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         fifo_empty;
   logic [W-1:0] fifo_data;
   logic         fifo_pop;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic [1:0]   occ;
   logic [C-1:0] xfer_cnt;

   always #5 clk = ~clk;

   fifo_drain_skid #(.WIDTH(W), .CNTW(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_pop   (fifo_pop),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .occ        (occ),
      .xfer_cnt   (xfer_cnt)
   );

   // Behavioural source FIFO: writes from the stimulus, pops on fifo_pop.
   logic [W-1:0] mem [256];
   logic [7:0]   wr;
   logic [7:0]   rd;
   assign fifo_empty = (rd == wr);
   assign fifo_data  = mem[rd];

   always @(posedge clk) begin
      if (rst) rd <= wr;
      else if (fifo_pop) rd <= rd + 8'd1;
   end

   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           exp_cnt  = 0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data  = '0;

   typedef struct {
      int           n_push;
      logic [W-1:0] base;
      logic         rdy;
      logic         fl;
      logic         ev;
      logic [W-1:0] ed;
      logic [1:0]   eo;
      logic         ep;
   } vec_t;
   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [W-1:0] d);
      mem[wr] = d;
      wr = wr + 8'd1;
      exp_q.push_back(d);
   endtask

   // Negedge: stall stability and in-order delivery checks.
   task automatic half();
      logic [W-1:0] e;
      @(negedge clk);
      if (!rst) begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && out_ready) begin
            exp_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("order", 32'(out_data), 32'(e));
            end
         end
      end
      prev_stall = out_valid && !out_ready && !rst && !flush;
      prev_data  = out_data;
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      half();
      finish_cycle();
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while (n < max && !(exp_q.size() == 0 && !out_valid && fifo_empty)) begin
         cycle();
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      chk("drain_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b0;
      wr = 8'd0;

      // Test 1 rows 0..4, test 2 rows 5..14 (n_push, base, rdy, fl, ev, ed, eo, ep)
      vecs[0]  = '{1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
      vecs[1]  = '{1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1};
      vecs[2]  = '{1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1};
      vecs[3]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1, 1'b0};
      vecs[4]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 2'd0, 1'b0};
      vecs[5]  = '{5, 8'hB0, 1'b0, 1'b0, 1'b0, 8'h33, 2'd0, 1'b1};
      vecs[6]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hB0, 2'd1, 1'b1};
      vecs[7]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hB0, 2'd2, 1'b0};
      vecs[8]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hB0, 2'd2, 1'b0};
      vecs[9]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB0, 2'd2, 1'b0};
      vecs[10] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB1, 2'd1, 1'b1};
      vecs[11] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB2, 2'd1, 1'b1};
      vecs[12] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB3, 2'd1, 1'b1};
      vecs[13] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB4, 2'd1, 1'b0};
      vecs[14] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB4, 2'd0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      half();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_cnt", 32'(xfer_cnt), 32'd0);
      chk("rst_pop", 32'(fifo_pop), 32'd0);
      finish_cycle();
      rst = 1'b0;

      // Tests 1 and 2: table-driven streaming and back-pressure
      for (int i = 0; i < 15; i++) begin
         for (int k = 0; k < vecs[i].n_push; k++) push_word(vecs[i].base + 8'(k));
         out_ready = vecs[i].rdy;
         flush = vecs[i].fl;
         half();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
         chk($sformatf("vec%0d_occ", i), 32'(occ), 32'(vecs[i].eo));
         chk($sformatf("vec%0d_pop", i), 32'(fifo_pop), 32'(vecs[i].ep));
         if (i == 4) chk("t1_cnt", 32'(xfer_cnt), 32'd3);
         finish_cycle();
      end
      chk("t2_cnt", 32'(xfer_cnt), 32'd8);

      // Test 3: out_ready toggling while the FIFO streams A0..A7
      for (int i = 0; i < 60; i++) begin
         if (i >= 8 && exp_q.size() == 0 && !out_valid) break;
         if (i < 8) push_word(8'hA0 + 8'(i));
         out_ready = (i % 2 == 0);
         cycle();
      end
      chk("t3_left", 32'(exp_q.size()), 32'd0);
      chk("t3_cnt", 32'(xfer_cnt), 32'(exp_cnt % 16));

      // Test 4: flush at occ=2 with a word still waiting in the FIFO
      out_ready = 1'b0;
      push_word(8'hC0);
      push_word(8'hC1);
      push_word(8'hC2);
      cycle();
      cycle();
      flush = 1'b1;
      half();
      chk("t4_occ_pre", 32'(occ), 32'd2);
      chk("t4_pop_flush", 32'(fifo_pop), 32'd0);
      finish_cycle();
      flush = 1'b0;
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      half();
      chk("t4_occ_post", 32'(occ), 32'd0);
      chk("t4_valid_post", 32'(out_valid), 32'd0);
      chk("t4_pop_post", 32'(fifo_pop), 32'd1);
      chk("t4_cnt_kept", 32'(xfer_cnt), 32'(exp_cnt % 16));
      finish_cycle();
      push_word(8'h5C);
      out_ready = 1'b1;
      drain(20);

      // Test 5a: reset at occ=2 with the FIFO non-empty
      out_ready = 1'b0;
      push_word(8'hD0);
      push_word(8'hD1);
      push_word(8'hD2);
      cycle();
      cycle();
      rst = 1'b1;
      half();
      chk("t5_occ_pre", 32'(occ), 32'd2);
      chk("t5_pop_rst", 32'(fifo_pop), 32'd0);
      finish_cycle();
      rst = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      half();
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_data", 32'(out_data), 32'd0);
      chk("t5_cnt", 32'(xfer_cnt), 32'd0);
      chk("t5_occ", 32'(occ), 32'd0);
      finish_cycle();

      // Test 5b: reset mid-stream while a pop would otherwise happen
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) push_word(8'h70 + 8'(k));
      cycle();
      cycle();
      rst = 1'b1;
      half();
      chk("t5b_pop_rst", 32'(fifo_pop), 32'd0);
      finish_cycle();
      rst = 1'b0;
      exp_q.delete();
      exp_cnt = 0;
      half();
      chk("t5b_valid", 32'(out_valid), 32'd0);
      chk("t5b_cnt", 32'(xfer_cnt), 32'd0);
      finish_cycle();

      // Test 6: 17 handshakes wrap the 4-bit counter to 1
      out_ready = 1'b1;
      for (int k = 0; k < 17; k++) push_word(8'hE0 + 8'(k));
      drain(60);
      chk("t6_wrap", 32'(xfer_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
